nn_manager: RTL and testbench

Memory-mapped control/register block for a two-layer neural-network datapath. A host writes weights and input activations through a simple address/data bus. The block drives them in parallel to the network, starts a run, and captures the network outputs after a fixed latency. It sits between the host bus and the network compute core.

---
 rtl/nn_manager.sv | 162 ++++++++++++++++
 tb/tb_nn_manager.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/nn_manager.sv
// Host register block for a two-layer NN core: holds weights/inputs, starts a run, captures outputs.
// Latency: writes visible next cycle; reads registered (1 cycle); result captured NET_LATENCY cycles after start.
// Backpressure: none; writes to weights/inputs/control are dropped while a run is in flight (RUN/DONE).
//
// Ports: clk/reset (sync, active-high); address/in_d/write/read host bus; out_d read data;
//        i_in network outputs; w_o weights (slot k = address k); i_o input activations;
//        d captured outputs; u status {0, result_valid, busy, weights_loaded};
//        wr run-start pulse; down result-captured pulse; ready = idle & weights loaded.
module nn_manager #(
  parameter int LENGHT_I    = 2,
  parameter int LENGHT_MID  = 2,
  parameter int LENGHT_O    = 2,
  parameter int WIDTH       = 4,
  parameter int WIDTH_W     = 4,
  parameter int WIDTH_I     = 1,
  parameter int WIDTH_O     = 4,
  parameter int WIDTH_ADDR  = $clog2(LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O + LENGHT_I + LENGHT_O + 3),
  parameter int NET_LATENCY = 10
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [WIDTH_ADDR-1:0]                     address,
  input  logic [WIDTH-1:0]                          in_d,
  input  logic                                      write,
  input  logic                                      read,
  input  logic [LENGHT_O*WIDTH_O-1:0]               i_in,
  output logic [WIDTH-1:0]                          out_d,
  output logic [(LENGHT_I*LENGHT_MID+LENGHT_MID*LENGHT_O)*WIDTH_W-1:0] w_o,
  output logic [LENGHT_I*WIDTH_I-1:0]               i_o,
  output logic [LENGHT_O*WIDTH_O-1:0]               d,
  output logic [WIDTH-1:0]                          u,
  output logic                                      wr,
  output logic                                      down,
  output logic                                      ready
);

  localparam int NW    = LENGHT_I*LENGHT_MID + LENGHT_MID*LENGHT_O;
  localparam int A_CW  = NW;
  localparam int A_I0  = NW + 1;
  localparam int A_CI  = NW + 1 + LENGHT_I;
  localparam int A_O0  = A_CI + 1;
  localparam int A_ST  = A_O0 + LENGHT_O;
  localparam int CNT_W = (NET_LATENCY > 1) ? $clog2(NET_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NW*WIDTH_W-1:0]           w_q, w_d;
  logic [LENGHT_I*WIDTH_I-1:0]     i_q, i_d;
  logic [LENGHT_O*WIDTH_O-1:0]     d_q, d_d;
  logic [WIDTH-1:0]                out_d_q, out_d_d;
  logic                            wl_q, wl_d;      // weights_loaded
  logic                            rv_q, rv_d;      // result_valid
  logic                            wr_q, wr_d;
  logic                            down_q, down_d;
  logic                            idle, busy;
  logic [3:0]                      status;
  logic [WIDTH-1:0]                rdata;

  assign idle   = (state_q == IDLE);
  assign busy   = ~idle;
  assign status = {1'b0, rv_q, busy, wl_q};

  // Read mux works on the current (pre-edge) register values, so a read and
  // write to the same address in one cycle returns the old contents.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NW; k++)
      if (address == WIDTH_ADDR'(k)) rdata = WIDTH'(w_q[k*WIDTH_W +: WIDTH_W]);
    if (address == WIDTH_ADDR'(A_CW)) rdata = WIDTH'(wl_q);
    for (int k = 0; k < LENGHT_I; k++)
      if (address == WIDTH_ADDR'(A_I0 + k)) rdata = WIDTH'(i_q[k*WIDTH_I +: WIDTH_I]);
    for (int k = 0; k < LENGHT_O; k++)
      if (address == WIDTH_ADDR'(A_O0 + k)) rdata = WIDTH'(d_q[k*WIDTH_O +: WIDTH_O]);
    if (address == WIDTH_ADDR'(A_ST)) rdata = WIDTH'(status);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    i_d     = i_q;
    d_d     = d_q;
    out_d_d = out_d_q;
    wl_d    = wl_q;
    rv_d    = rv_q;
    wr_d    = 1'b0;
    down_d  = 1'b0;

    // Configuration writes are only accepted while idle so the core sees
    // stable weights and inputs for the whole run.
    if (write && idle) begin
      for (int k = 0; k < NW; k++)
        if (address == WIDTH_ADDR'(k)) w_d[k*WIDTH_W +: WIDTH_W] = WIDTH_W'(in_d);
      for (int k = 0; k < LENGHT_I; k++)
        if (address == WIDTH_ADDR'(A_I0 + k)) i_d[k*WIDTH_I +: WIDTH_I] = WIDTH_I'(in_d);
      if (address == WIDTH_ADDR'(A_CW)) wl_d = in_d[0];
    end

    case (state_q)
      IDLE: begin
        if (write && (address == WIDTH_ADDR'(A_CI)) && in_d[0] && wl_q) begin
          state_d = RUN;
          cnt_d   = CNT_W'(NET_LATENCY - 1);
          wr_d    = 1'b1;
          rv_d    = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          d_d     = i_in;
          rv_d    = 1'b1;
          down_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (read) out_d_d = rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
      i_q     <= '0;
      d_q     <= '0;
      out_d_q <= '0;
      wl_q    <= 1'b0;
      rv_q    <= 1'b0;
      wr_q    <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      i_q     <= i_d;
      d_q     <= d_d;
      out_d_q <= out_d_d;
      wl_q    <= wl_d;
      rv_q    <= rv_d;
      wr_q    <= wr_d;
      down_q  <= down_d;
    end
  end

  assign w_o   = w_q;
  assign i_o   = i_q;
  assign d     = d_q;
  assign out_d = out_d_q;
  assign u     = WIDTH'(status);
  assign wr    = wr_q;
  assign down  = down_q;
  assign ready = wl_q & idle;

endmodule

// File: tb/tb_nn_manager.sv
module tb_nn_manager;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic [3:0]  in_d;
  logic        write;
  logic        read;
  logic [7:0]  i_in;
  logic [3:0]  out_d;
  logic [31:0] w_o;
  logic [1:0]  i_o;
  logic [7:0]  d;
  logic [3:0]  u;
  logic        wr;
  logic        down;
  logic        ready;

  int n_cmp  = 0;
  int n_fail = 0;

  nn_manager dut (
    .clk(clk), .reset(reset), .address(address), .in_d(in_d), .write(write),
    .read(read), .i_in(i_in), .out_d(out_d), .w_o(w_o), .i_o(i_o), .d(d),
    .u(u), .wr(wr), .down(down), .ready(ready)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] v);
    address = a; in_d = v; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; write = 1'b0; read = 1'b0; address = '0; in_d = '0; i_in = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%0b exp=0", ready); end
    n_cmp++; if (u !== 4'h0) begin n_fail++; $display("FAIL reset_u got=%h exp=0", u); end
    n_cmp++; if (wr !== 1'b0 || down !== 1'b0) begin n_fail++; $display("FAIL reset_pulses wr=%0b down=%0b exp=0", wr, down); end
    n_cmp++; if (w_o !== 32'h0 || i_o !== 2'b00 || d !== 8'h00) begin n_fail++; $display("FAIL reset_regs w_o=%h i_o=%b d=%h exp=0", w_o, i_o, d); end
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a));
      n_cmp++; if (out_d !== 4'h0) begin n_fail++; $display("FAIL reset_read addr=%0d got=%h exp=0", a, out_d); end
    end
  endtask

  task automatic test_weights();
    for (int k = 0; k < 8; k++) do_write(4'(k), 4'(k));
    n_cmp++; if (w_o !== 32'h76543210) begin n_fail++; $display("FAIL weights_w_o got=%h exp=76543210", w_o); end
    for (int k = 0; k < 8; k++) begin
      do_read(4'(k));
      n_cmp++; if (out_d !== 4'(k)) begin n_fail++; $display("FAIL weight_read addr=%0d got=%h exp=%h", k, out_d, 4'(k)); end
    end
    // Same-cycle read and write of address 3: old value read, new value stored.
    address = 4'd3; in_d = 4'hC; write = 1'b1; read = 1'b1;
    tick();
    write = 1'b0; read = 1'b0;
    n_cmp++; if (out_d !== 4'h3) begin n_fail++; $display("FAIL rw_same_read got=%h exp=3", out_d); end
    n_cmp++; if (w_o !== 32'h7654C210) begin n_fail++; $display("FAIL rw_same_w_o got=%h exp=7654C210", w_o); end
    n_cmp++; if (ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_load got=%0b exp=0", ready); end
    do_write(4'd8, 4'hF);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_load got=%0b exp=1", ready); end
    n_cmp++; if (u !== 4'b0001) begin n_fail++; $display("FAIL u_after_load got=%b exp=0001", u); end
    n_cmp++; if (out_d !== 4'h3) begin n_fail++; $display("FAIL out_d_hold got=%h exp=3", out_d); end
  endtask

  task automatic test_inputs();
    do_write(4'd9, 4'h0);
    do_write(4'd10, 4'h1);
    n_cmp++; if (i_o !== 2'b10) begin n_fail++; $display("FAIL inputs_i_o got=%b exp=10", i_o); end
    do_write(4'd10, 4'hE);
    n_cmp++; if (i_o !== 2'b00) begin n_fail++; $display("FAIL input_trunc_E got=%b exp=00", i_o); end
    do_write(4'd10, 4'h3);
    n_cmp++; if (i_o !== 2'b10) begin n_fail++; $display("FAIL input_trunc_3 got=%b exp=10", i_o); end
    do_read(4'd10);
    n_cmp++; if (out_d !== 4'h1) begin n_fail++; $display("FAIL input_read got=%h exp=1", out_d); end
    do_read(4'd11);
    n_cmp++; if (out_d !== 4'h0) begin n_fail++; $display("FAIL read_ctrl_idle got=%h exp=0", out_d); end
    do_write(4'd15, 4'hF);
    n_cmp++; if (w_o !== 32'h7654C210 || i_o !== 2'b10 || u !== 4'b0001 || ready !== 1'b1 || wr !== 1'b0) begin
      n_fail++; $display("FAIL unmapped_write w_o=%h i_o=%b u=%b ready=%0b wr=%0b", w_o, i_o, u, ready, wr);
    end
    do_read(4'd15);
    n_cmp++; if (out_d !== 4'h0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=0", out_d); end
  endtask

  task automatic test_back_to_back();
    int n;
    i_in = 8'h00;
    address = 4'd11; in_d = 4'hF; write = 1'b1;
    tick();  // E0
    n_cmp++; if (wr !== 1'b1 || u !== 4'b0011 || ready !== 1'b0) begin n_fail++; $display("FAIL start_E0 wr=%0b u=%b ready=%0b exp 1/0011/0", wr, u, ready); end
    tick();  // E0+1
    n_cmp++; if (wr !== 1'b0) begin n_fail++; $display("FAIL wr_one_cycle got=%0b exp=0", wr); end
    for (int i = 2; i <= 7; i++) tick();
    i_in = 8'h01;
    tick(); tick();  // E0+9
    n_cmp++; if (down !== 1'b0 || d !== 8'h00) begin n_fail++; $display("FAIL pre_capture down=%0b d=%h exp 0/00", down, d); end
    tick();  // E0+10
    n_cmp++; if (d !== 8'h01 || down !== 1'b1 || u !== 4'b0111 || ready !== 1'b0) begin
      n_fail++; $display("FAIL capture d=%h down=%0b u=%b ready=%0b exp 01/1/0111/0", d, down, u, ready);
    end
    tick();  // E0+11
    n_cmp++; if (down !== 1'b0 || ready !== 1'b1 || wr !== 1'b0 || u !== 4'b0101) begin
      n_fail++; $display("FAIL after_done down=%0b ready=%0b wr=%0b u=%b exp 0/1/0/0101", down, ready, wr, u);
    end
    tick();  // E0+12: held write restarts the run
    n_cmp++; if (wr !== 1'b1 || u !== 4'b0011 || ready !== 1'b0) begin
      n_fail++; $display("FAIL restart wr=%0b u=%b ready=%0b exp 1/0011/0", wr, u, ready);
    end
    write = 1'b0;
    i_in = 8'h5A;
    do_write(4'd0, 4'h9);
    n_cmp++; if (w_o[3:0] !== 4'h0) begin n_fail++; $display("FAIL busy_weight_lock got=%h exp=0", w_o[3:0]); end
    do_write(4'd9, 4'h1);
    n_cmp++; if (i_o !== 2'b10) begin n_fail++; $display("FAIL busy_input_lock got=%b exp=10", i_o); end
    do_read(4'd14);
    n_cmp++; if (out_d !== 4'b0011) begin n_fail++; $display("FAIL busy_status_read got=%b exp=0011", out_d); end
    do_write(4'd8, 4'h0);  // E0+16
    n_cmp++; if (u !== 4'b0011) begin n_fail++; $display("FAIL busy_cw_lock got=%b exp=0011", u); end
    n = 0;
    while (down !== 1'b1 && n < 20) begin tick(); n++; end
    n_cmp++; if (down !== 1'b1 || n != 6) begin n_fail++; $display("FAIL second_capture_time down=%0b cycles=%0d exp 1/6", down, n); end
    n_cmp++; if (d !== 8'h5A) begin n_fail++; $display("FAIL second_capture_d got=%h exp=5a", d); end
    tick();
    n_cmp++; if (ready !== 1'b1 || u !== 4'b0101) begin n_fail++; $display("FAIL second_idle ready=%0b u=%b exp 1/0101", ready, u); end
  endtask

  task automatic test_no_weights();
    do_write(4'd8, 4'h0);
    n_cmp++; if (ready !== 1'b0 || u !== 4'b0100) begin n_fail++; $display("FAIL unload ready=%0b u=%b exp 0/0100", ready, u); end
    do_write(4'd11, 4'h1);
    n_cmp++; if (wr !== 1'b0 || u !== 4'b0100) begin n_fail++; $display("FAIL start_no_weights wr=%0b u=%b exp 0/0100", wr, u); end
    tick(); tick();
    n_cmp++; if (wr !== 1'b0 || u !== 4'b0100 || down !== 1'b0) begin n_fail++; $display("FAIL stay_idle wr=%0b u=%b down=%0b", wr, u, down); end
  endtask

  task automatic test_reset_mid_run();
    do_write(4'd8, 4'h1);
    n_cmp++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reload_ready got=%0b exp=1", ready); end
    do_read(4'd14);
    n_cmp++; if (out_d !== 4'b0101) begin n_fail++; $display("FAIL status_read got=%b exp=0101", out_d); end
    i_in = 8'hFF;
    do_write(4'd11, 4'h1);
    n_cmp++; if (wr !== 1'b1 || u !== 4'b0011) begin n_fail++; $display("FAIL start3 wr=%0b u=%b exp 1/0011", wr, u); end
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    n_cmp++; if (w_o !== 32'h0 || i_o !== 2'b00 || d !== 8'h00 || out_d !== 4'h0) begin
      n_fail++; $display("FAIL midrun_reset_regs w_o=%h i_o=%b d=%h out_d=%h exp 0", w_o, i_o, d, out_d);
    end
    n_cmp++; if (u !== 4'h0 || wr !== 1'b0 || down !== 1'b0 || ready !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset_flags u=%b wr=%0b down=%0b ready=%0b exp 0", u, wr, down, ready);
    end
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    n_cmp++; if (d !== 8'h00 || down !== 1'b0 || u !== 4'h0) begin n_fail++; $display("FAIL run_aborted d=%h down=%0b u=%b exp 0", d, down, u); end
    do_write(4'd8, 4'h1);
    n_cmp++; if (ready !== 1'b1 || u !== 4'b0001) begin n_fail++; $display("FAIL idle_after_reset ready=%0b u=%b exp 1/0001", ready, u); end
  endtask

  initial begin
    test_reset();
    test_weights();
    test_inputs();
    test_back_to_back();
    test_no_weights();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
